// File: rtl/xgmii_frame_capture.sv
// XGMII TX frame capture: idle-delimited store-and-forward buffer
// with valid/ready replay and fill-level / periodic pause generation.
module xgmii_frame_capture #(
    parameter int XGMII_DATA_WIDTH = 32,
    parameter int XGMII_CTRL_WIDTH = 4,
    parameter int DEPTH            = 512,
    parameter int PAUSE_THRESH     = 8,
    parameter int PAUSE_PERIOD     = 0
) (
    input  logic                        clk,
    input  logic                        i_reset_n,
    input  logic [XGMII_DATA_WIDTH-1:0] i_xgmii_txd,
    input  logic [XGMII_CTRL_WIDTH-1:0] i_xgmii_ctrl,
    input  logic                        i_xgmii_valid,
    output logic                        o_xgmii_pause,
    input  logic                        i_pause_en,
    output logic [XGMII_DATA_WIDTH-1:0] o_cap_data,
    output logic [XGMII_CTRL_WIDTH-1:0] o_cap_ctrl,
    output logic                        o_cap_last,
    output logic                        o_cap_valid,
    input  logic                        i_cap_ready,
    output logic [15:0]                 o_frame_cnt,
    output logic [15:0]                 o_drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = XGMII_DATA_WIDTH + XGMII_CTRL_WIDTH + 1;
    localparam logic [AW:0] DEPTH_M1 = (AW+1)'(DEPTH - 1);
    localparam logic [31:0] THRESH32 = 32'(PAUSE_THRESH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CAPT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [EW-1:0] mem [DEPTH];

    logic [1:0]  state;
    logic [AW:0] wr_ptr;
    logic [AW:0] commit_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_nxt;
    logic [AW:0] used;
    logic [AW:0] free_cnt;
    logic        is_idle;
    logic        non_idle;
    logic        full;
    logic        wr_en;
    logic        empty;
    logic        load;
    logic        low_free;
    logic        periodic;

    assign is_idle  = i_xgmii_valid && (&i_xgmii_ctrl);
    assign non_idle = i_xgmii_valid && !(&i_xgmii_ctrl);
    assign wr_nxt   = wr_ptr + 1'b1;

    // One slot stays reserved: full when the next write would meet rd_ptr.
    assign full = (wr_nxt[AW-1:0] == rd_ptr[AW-1:0]) &&
                  (wr_nxt[AW] != rd_ptr[AW]);

    assign wr_en = !full &&
                   (((state == S_IDLE) && non_idle) ||
                    ((state == S_CAPT) && i_xgmii_valid));

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= {is_idle, i_xgmii_ctrl, i_xgmii_txd};
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            o_frame_cnt <= '0;
            o_drop_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (non_idle) begin
                        if (full) begin
                            state <= S_DROP;
                        end else begin
                            wr_ptr <= wr_nxt;
                            state  <= S_CAPT;
                        end
                    end
                end
                S_CAPT: begin
                    if (i_xgmii_valid) begin
                        if (full) begin
                            wr_ptr <= commit_ptr;
                            if (is_idle) begin
                                o_drop_cnt <= o_drop_cnt + 16'd1;
                                state      <= S_IDLE;
                            end else begin
                                state <= S_DROP;
                            end
                        end else begin
                            wr_ptr <= wr_nxt;
                            if (is_idle) begin
                                commit_ptr  <= wr_nxt;
                                o_frame_cnt <= o_frame_cnt + 16'd1;
                                state       <= S_IDLE;
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (is_idle) begin
                        o_drop_cnt <= o_drop_cnt + 16'd1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign empty = (rd_ptr == commit_ptr);
    assign load  = !empty && (!o_cap_valid || i_cap_ready);

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_ptr      <= '0;
            o_cap_valid <= 1'b0;
            o_cap_last  <= 1'b0;
            o_cap_ctrl  <= '0;
            o_cap_data  <= '0;
        end else if (load) begin
            {o_cap_last, o_cap_ctrl, o_cap_data} <= mem[rd_ptr[AW-1:0]];
            o_cap_valid <= 1'b1;
            rd_ptr      <= rd_ptr + 1'b1;
        end else if (i_cap_ready) begin
            o_cap_valid <= 1'b0;
        end
    end

    assign used     = wr_ptr - rd_ptr;
    assign free_cnt = DEPTH_M1 - used;
    assign low_free = (32'(free_cnt) < THRESH32);

    generate
        if (PAUSE_PERIOD > 1) begin : g_per
            localparam int PW = $clog2(PAUSE_PERIOD);
            localparam logic [PW-1:0] PER_LAST = PW'(PAUSE_PERIOD - 1);
            logic [PW-1:0] per_cnt;
            always_ff @(posedge clk or negedge i_reset_n) begin
                if (!i_reset_n)
                    per_cnt <= '0;
                else if (per_cnt == PER_LAST)
                    per_cnt <= '0;
                else
                    per_cnt <= per_cnt + 1'b1;
            end
            assign periodic = i_pause_en && (per_cnt == PER_LAST);
        end else begin : g_noper
            assign periodic = i_pause_en & 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n)
            o_xgmii_pause <= 1'b0;
        else
            o_xgmii_pause <= low_free | periodic;
    end

endmodule

// File: tb/tb_xgmii_frame_capture.sv
// Randomised scoreboard bench for xgmii_frame_capture: a frame-level
// model predicts replayed words, a negedge monitor compares them.
module tb_xgmii_frame_capture;

    localparam int DW    = 32;
    localparam int CW    = 4;
    localparam int DEPTH = 64;
    localparam int THR   = 8;
    localparam int PER   = 4;
    localparam int BIG   = 1000000;

    logic          clk = 1'b0;
    logic          i_reset_n;
    logic [DW-1:0] i_xgmii_txd;
    logic [CW-1:0] i_xgmii_ctrl;
    logic          i_xgmii_valid;
    logic          o_xgmii_pause;
    logic          i_pause_en;
    logic [DW-1:0] o_cap_data;
    logic [CW-1:0] o_cap_ctrl;
    logic          o_cap_last;
    logic          o_cap_valid;
    logic          i_cap_ready;
    logic [15:0]   o_frame_cnt;
    logic [15:0]   o_drop_cnt;

    always #5 clk = ~clk;

    xgmii_frame_capture #(
        .XGMII_DATA_WIDTH(DW),
        .XGMII_CTRL_WIDTH(CW),
        .DEPTH(DEPTH),
        .PAUSE_THRESH(THR),
        .PAUSE_PERIOD(PER)
    ) dut (
        .clk(clk),
        .i_reset_n(i_reset_n),
        .i_xgmii_txd(i_xgmii_txd),
        .i_xgmii_ctrl(i_xgmii_ctrl),
        .i_xgmii_valid(i_xgmii_valid),
        .o_xgmii_pause(o_xgmii_pause),
        .i_pause_en(i_pause_en),
        .o_cap_data(o_cap_data),
        .o_cap_ctrl(o_cap_ctrl),
        .o_cap_last(o_cap_last),
        .o_cap_valid(o_cap_valid),
        .i_cap_ready(i_cap_ready),
        .o_frame_cnt(o_frame_cnt),
        .o_drop_cnt(o_drop_cnt)
    );

    typedef struct packed {
        logic          last;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } word_t;

    word_t exp_q[$];
    word_t frm_q[$];
    int    hits[$];
    bit    in_frame;
    int    room;
    int    exp_frames;
    int    exp_drops;
    int    n_chk;
    int    n_fail;
    int    rdy_mode;
    word_t prev_w;
    bit    prev_stall;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Frame-level model: a frame is its non-idle run plus the idle that
    // ends it; it is kept whole if it fits the room left, else dropped.
    function automatic void model_word(input logic [CW-1:0] c,
                                       input logic [DW-1:0] d);
        if (c != 4'hF) begin
            in_frame = 1'b1;
            frm_q.push_back({1'b0, c, d});
        end else if (in_frame) begin
            frm_q.push_back({1'b1, c, d});
            if (frm_q.size() <= room) begin
                room -= frm_q.size();
                foreach (frm_q[i]) exp_q.push_back(frm_q[i]);
                exp_frames++;
            end else begin
                exp_drops++;
            end
            frm_q.delete();
            in_frame = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic v, input logic [CW-1:0] c,
                        input logic [DW-1:0] d);
        i_xgmii_valid = v;
        i_xgmii_ctrl  = c;
        i_xgmii_txd   = d;
        if (v) model_word(c, d);
        tick();
        i_xgmii_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input int pre, input bit gaps);
        repeat (pre) send(1'b1, 4'hF, $urandom);
        for (int i = 0; i < n; i++) begin
            send(1'b1, 4'($urandom_range(0, 14)), $urandom);
            if (gaps && $urandom_range(0, 3) == 0)
                send(1'b0, 4'($urandom), $urandom);
        end
        send(1'b1, 4'hF, $urandom);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            tick();
            k++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        repeat (3) tick();
    endtask

    initial begin
        i_cap_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       i_cap_ready = 1'b0;
                1:       i_cap_ready = 1'b1;
                default: i_cap_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        word_t cur;
        cur = {o_cap_last, o_cap_ctrl, o_cap_data};
        if (!i_reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold_stable", 64'({o_cap_valid, cur}),
                    64'({1'b1, prev_w}));
            if (o_cap_valid && i_cap_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL replay_extra: got %h, want none", cur);
                end else begin
                    chk("replay", 64'(cur), 64'(exp_q.pop_front()));
                end
            end
            prev_stall = o_cap_valid && !i_cap_ready;
            prev_w     = cur;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0; room = BIG; rdy_mode = 1;
        in_frame = 1'b0; exp_frames = 0; exp_drops = 0;
        prev_stall = 1'b0; prev_w = '0;
        i_reset_n = 1'b0; i_xgmii_valid = 1'b0;
        i_xgmii_ctrl = '0; i_xgmii_txd = '0; i_pause_en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", 64'(o_cap_valid), 64'd0);
        chk("rst_pause", 64'(o_xgmii_pause), 64'd0);
        chk("rst_word", 64'({o_cap_last, o_cap_ctrl, o_cap_data}), 64'd0);
        chk("rst_cnts", 64'({o_frame_cnt, o_drop_cnt}), 64'd0);
        i_reset_n = 1'b1;
        tick();

        // 3 idles, 16 data words, idle -> 17 entries
        repeat (3) send(1'b1, 4'hF, $urandom);
        send_frame(16, 0, 1'b0);
        wait_drain("t1_drain");
        chk("t1_frame_cnt", 64'(o_frame_cnt), 64'(16'(exp_frames)));

        // stall the replay mid-frame
        send_frame(20, 0, 1'b0);
        repeat (4) tick();
        rdy_mode = 0;
        repeat (10) tick();
        rdy_mode = 1;
        wait_drain("t3_drain");

        // valid=0 gaps with garbage, including idle-looking ctrl
        for (int i = 0; i < 3; i++) send(1'b1, 4'($urandom_range(0, 14)), $urandom);
        send(1'b0, 4'hF, $urandom);
        send(1'b0, 4'($urandom), $urandom);
        send(1'b0, 4'h0, $urandom);
        for (int i = 0; i < 3; i++) send(1'b1, 4'($urandom_range(0, 14)), $urandom);
        send(1'b1, 4'hF, $urandom);
        wait_drain("t6_gap_drain");

        // random batches with random backpressure
        rdy_mode = 2;
        for (int b = 0; b < 6; b++) begin
            for (int f = 0; f < 5; f++)
                send_frame($urandom_range(1, 8), $urandom_range(0, 3), 1'b1);
            wait_drain("rand_drain");
            chk("rand_frame_cnt", 64'(o_frame_cnt), 64'(16'(exp_frames)));
        end

        // oversize frame dropped, following frame kept
        rdy_mode = 1;
        tick();
        rdy_mode = 0;
        repeat (3) tick();
        room = DEPTH - 1;
        send_frame(70, 0, 1'b0);
        send_frame(5, 1, 1'b0);
        repeat (5) tick();
        chk("t2_drop_cnt", 64'(o_drop_cnt), 64'(16'(exp_drops)));
        chk("t2_frame_cnt", 64'(o_frame_cnt), 64'(16'(exp_frames)));
        chk("t2_valid", 64'(o_cap_valid), 64'd1);
        rdy_mode = 1;
        wait_drain("t2_drain");
        room = BIG;

        // fill threshold: 54 buffered (free 9), then 56 (free 7)
        rdy_mode = 0;
        room = DEPTH - 1;
        send_frame(54, 0, 1'b0);
        repeat (4) tick();
        chk("t4_pause_free9", 64'(o_xgmii_pause), 64'd0);
        send_frame(1, 0, 1'b0);
        repeat (4) tick();
        chk("t4_pause_free7", 64'(o_xgmii_pause), 64'd1);
        rdy_mode = 1;
        wait_drain("t4_drain");
        chk("t4_pause_drained", 64'(o_xgmii_pause), 64'd0);
        room = BIG;

        // periodic pause
        i_pause_en = 1'b1;
        repeat (2) tick();
        hits.delete();
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (o_xgmii_pause) hits.push_back(i);
        end
        chk("t5_count", 64'(hits.size()), 64'd6);
        for (int i = 1; i < hits.size(); i++)
            chk("t5_gap", 64'(hits[i] - hits[i-1]), 64'd4);
        tick();
        i_pause_en = 1'b0;
        repeat (2) tick();
        hits.delete();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_xgmii_pause) hits.push_back(i);
        end
        chk("t5_off", 64'(hits.size()), 64'd0);
        tick();

        // reset in the middle of a frame
        for (int i = 0; i < 5; i++) send(1'b1, 4'($urandom_range(0, 14)), $urandom);
        i_reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(o_cap_valid), 64'd0);
        chk("mid_rst_word", 64'({o_cap_last, o_cap_ctrl, o_cap_data}), 64'd0);
        chk("mid_rst_cnts", 64'({o_frame_cnt, o_drop_cnt}), 64'd0);
        chk("mid_rst_pause", 64'(o_xgmii_pause), 64'd0);
        exp_q.delete();
        frm_q.delete();
        in_frame = 1'b0;
        exp_frames = 0;
        exp_drops = 0;
        @(posedge clk);
        #2;
        i_reset_n = 1'b1;
        tick();
        send_frame(6, 1, 1'b0);
        wait_drain("t6_rst_drain");
        chk("t6_frame_cnt", 64'(o_frame_cnt), 64'(16'(exp_frames)));
        chk("t6_drop_cnt", 64'(o_drop_cnt), 64'(16'(exp_drops)));
        chk("end_queue", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
